// File: rtl/blink_pkg.sv
// Shared constants and state encodings for the blink command receiver.
package blink_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [7:0] CMD_SET_PERIOD = 8'h01;
  localparam logic [7:0] CMD_SET_MASK   = 8'h02;

  localparam logic [2:0] LEN_PERIOD = 3'd4;
  localparam logic [2:0] LEN_MASK   = 3'd1;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [1:0] {
    PsIdle,
    PsCmd,
    PsPayload,
    PsChk
  } ps_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser.
module uart_rx_byte
  import blink_pkg::*;
#(
  parameter int unsigned DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  rx_state_e     state_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      state_q    <= RxIdle;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      prev_q     <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        RxIdle: begin
          if (prev_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= RxStart;
          end
        end
        RxStart: begin
          // Mid-start-bit re-sample rejects short low glitches.
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= RxStop;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rx_s) begin
              data       <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/blink_cmd_rx.sv
// Framed UART command parser driving the blinker half-period and LED mask.
module blink_cmd_rx
  import blink_pkg::*;
#(
  parameter int unsigned CLK_FREQ            = 25_000_000,
  parameter int unsigned BAUD                = 115_200,
  parameter logic [31:0] DEFAULT_HALF_PERIOD = 32'(CLK_FREQ / 4),
  parameter logic [7:0]  DEFAULT_MASK        = 8'h03,
  parameter int unsigned TIMEOUT_CYCLES      = CLK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] half_period,
  output logic [7:0]  led_mask,
  output logic        cfg_valid,
  output logic        frame_err,
  output logic        cmd_err
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;

  ps_state_e     st_q;
  logic [2:0]    cnt_q;
  logic [7:0]    xor_q;
  logic [31:0]   shadow_q;
  logic          is_period_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .data       (rx_data),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr)
  );

  assign frame_err = rx_ferr;

  always_comb begin
    tmo_hit = (st_q != PsIdle) && !rx_valid && (tmo_q == TMO_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= PsIdle;
      cnt_q       <= '0;
      xor_q       <= '0;
      shadow_q    <= '0;
      is_period_q <= 1'b0;
      tmo_q       <= '0;
      half_period <= DEFAULT_HALF_PERIOD;
      led_mask    <= DEFAULT_MASK;
      cfg_valid   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (tmo_hit || rx_ferr) begin
        // Either abort drops the frame; both pulses may fire together.
        st_q    <= PsIdle;
        tmo_q   <= '0;
        cmd_err <= tmo_hit;
      end else if (rx_valid) begin
        tmo_q <= '0;
        case (st_q)
          PsIdle: begin
            if (rx_data == SYNC_BYTE) st_q <= PsCmd;
          end
          PsCmd: begin
            xor_q <= rx_data;
            if (rx_data == CMD_SET_PERIOD) begin
              is_period_q <= 1'b1;
              cnt_q       <= LEN_PERIOD;
              st_q        <= PsPayload;
            end else if (rx_data == CMD_SET_MASK) begin
              is_period_q <= 1'b0;
              cnt_q       <= LEN_MASK;
              st_q        <= PsPayload;
            end else begin
              cmd_err <= 1'b1;
              st_q    <= PsIdle;
            end
          end
          PsPayload: begin
            shadow_q <= {shadow_q[23:0], rx_data};
            xor_q    <= xor_q ^ rx_data;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == 3'd1) st_q <= PsChk;
          end
          PsChk: begin
            st_q <= PsIdle;
            if (rx_data != xor_q) begin
              cmd_err <= 1'b1;
            end else if (is_period_q) begin
              if (shadow_q == 32'd0) begin
                cmd_err <= 1'b1;
              end else begin
                half_period <= shadow_q;
                cfg_valid   <= 1'b1;
              end
            end else begin
              led_mask  <= shadow_q[7:0];
              cfg_valid <= 1'b1;
            end
          end
          default: st_q <= PsIdle;
        endcase
      end else if (st_q != PsIdle) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_blink_cmd_rx.sv
// Directed table-driven bench for blink_cmd_rx with a 10-clock UART bit time.
module tb_blink_cmd_rx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned TMO      = 500;
  localparam int          BIT      = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [31:0] half_period;
  logic [7:0]  led_mask;
  logic        cfg_valid;
  logic        frame_err;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;
  int n_cfg = 0, n_cmd = 0, n_frm = 0;
  int b_cfg, b_cmd, b_frm;

  blink_cmd_rx #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .half_period (half_period),
    .led_mask    (led_mask),
    .cfg_valid   (cfg_valid),
    .frame_err   (frame_err),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_valid === 1'b1) n_cfg++;
      if (cmd_err === 1'b1)   n_cmd++;
      if (frame_err === 1'b1) n_frm++;
    end
  end

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          bad;
    logic [31:0] hp;
    logic [7:0]  mask;
    int          cfg;
    int          cmd;
    int          frm;
  } vec_t;

  vec_t vecs[9];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mark();
    b_cfg = n_cfg;
    b_cmd = n_cmd;
    b_frm = n_frm;
  endtask

  task automatic check_counts(input string tag, input int ecfg, input int ecmd, input int efrm);
    check32({tag, " cfg_valid pulses"}, 32'(n_cfg - b_cfg), 32'(ecfg));
    check32({tag, " cmd_err pulses"},   32'(n_cmd - b_cmd), 32'(ecmd));
    check32({tag, " frame_err pulses"}, 32'(n_frm - b_frm), 32'(efrm));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [63:0] bytes, input int n, input int bad);
    logic [63:0] f;
    f = bytes;
    for (int k = 0; k < n; k++) send_byte(f[63-8*k -: 8], (k == bad) ? 1'b0 : 1'b1);
  endtask

  initial begin
    vecs[0] = '{64'hA501_0000_000A_0B00, 7, -1, 32'd10,         8'h03, 1, 0, 0};
    vecs[1] = '{64'hA502_F0F2_0000_0000, 4, -1, 32'd10,         8'hF0, 1, 0, 0};
    vecs[2] = '{64'hA502_5500_0000_0000, 4, -1, 32'd10,         8'hF0, 0, 1, 0};
    vecs[3] = '{64'hA501_0000_0000_0100, 7, -1, 32'd10,         8'hF0, 0, 1, 0};
    vecs[4] = '{64'hA507_0000_0000_0000, 2, -1, 32'd10,         8'hF0, 0, 1, 0};
    vecs[5] = '{64'h00A5_0281_8300_0000, 5, -1, 32'd10,         8'h81, 1, 0, 0};
    vecs[6] = '{64'hA501_0012_0000_0000, 4,  3, 32'd10,         8'h81, 0, 0, 1};
    vecs[7] = '{64'hA501_0001_86A0_2600, 7, -1, 32'h0001_86A0, 8'h81, 1, 0, 0};
    vecs[8] = '{64'hA501_A500_00A5_0100, 7, -1, 32'hA500_00A5, 8'h81, 1, 0, 0};

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    mark();
    repeat (2000) @(negedge clk);
    check32("reset half_period", half_period, 32'd250_000);
    check32("reset led_mask", 32'(led_mask), 32'h03);
    check_counts("idle", 0, 0, 0);

    for (int v = 0; v < 9; v++) begin
      mark();
      send_frame(vecs[v].bytes, vecs[v].n, vecs[v].bad);
      repeat (3 * BIT) @(negedge clk);
      check32($sformatf("vec%0d half_period", v), half_period, vecs[v].hp);
      check32($sformatf("vec%0d led_mask", v), 32'(led_mask), 32'(vecs[v].mask));
      check_counts($sformatf("vec%0d", v), vecs[v].cfg, vecs[v].cmd, vecs[v].frm);
    end

    // Inter-byte timeout after the command byte.
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (600) @(negedge clk);
    check_counts("timeout", 0, 1, 0);
    check32("timeout led_mask", 32'(led_mask), 32'h81);
    mark();
    send_frame(64'hA502_3C3E_0000_0000, 4, -1);
    repeat (3 * BIT) @(negedge clk);
    check32("post-timeout led_mask", 32'(led_mask), 32'h3C);
    check_counts("post-timeout", 1, 0, 0);

    // Short low glitch must not start a byte.
    mark();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check_counts("glitch", 0, 0, 0);
    check32("glitch led_mask", 32'(led_mask), 32'h3C);

    // Reset during the payload of a SET_PERIOD.
    send_frame(64'hA501_0000_0000_0000, 4, -1);
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check32("midframe reset half_period", half_period, 32'd250_000);
    check32("midframe reset led_mask", 32'(led_mask), 32'h03);
    rst = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    mark();
    send_frame(64'hA501_0000_0100_0000, 7, -1);
    repeat (3 * BIT) @(negedge clk);
    check32("after reset half_period", half_period, 32'd256);
    check32("after reset led_mask", 32'(led_mask), 32'h03);
    check_counts("after reset", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
